pipe_stage_skid: RTL and testbench

//   Parametrised pipeline stage register for the RISC-V pipeline (IF/ID .. MEM/WB).

---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush,
// control-sideband kill on bubbles and a saturating backpressure stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned CNT_W    = 16,
    parameter bit          CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        r_state, w_state_d;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data, w_main_data_d;
    logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_d;
    logic [DATA_W-1:0] r_skid_data, w_skid_data_d;
    logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_d;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        w_state_d     = r_state;
        w_main_data_d = r_main_data;
        w_main_ctrl_d = r_main_ctrl;
        w_skid_data_d = r_skid_data;
        w_skid_ctrl_d = r_skid_ctrl;
        if (flush) begin
            // Anything accepted this cycle is discarded along with held entries.
            w_state_d = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_d     = ST_ONE;
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                    end else if (w_in_fire) begin
                        w_state_d     = ST_FULL;
                        w_skid_data_d = in_data;
                        w_skid_ctrl_d = in_ctrl;
                    end else if (w_out_fire) begin
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_d     = ST_ONE;
                        w_main_data_d = r_skid_data;
                        w_main_ctrl_d = r_skid_ctrl;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            // Registered ready derived from next state only, never from out_ready.
            r_in_ready  <= (w_state_d != ST_FULL);
            r_main_data <= w_main_data_d;
            r_main_ctrl <= w_main_ctrl_d;
            r_skid_data <= w_skid_data_d;
            r_skid_ctrl <= w_skid_ctrl_d;
            if (w_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = (CLR_DATA && !w_out_valid) ? '0 : r_main_data;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming,
// backpressure, flush, stall counter saturation and mid-operation reset.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W),
        .CLR_DATA(1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        push(16'h00AA, 8'hAA);
        #1;

        // 1: reset held 2 cycles with in_valid high
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_occupancy", occupancy, 0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_out_valid", out_valid, 0);

        // 2: streaming 1..10
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push(DATA_W'(i), CTRL_W'(i + 16));
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
            chk("stream_ctrl", out_ctrl, i + 16);
            chk("stream_in_ready", in_ready, 1);
            chk("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_drain_ctrl", out_ctrl, 0);
        chk("stream_stall", stall_cnt, 0);

        // 3: backpressure A, B, C
        out_ready = 1'b0;
        push(16'h00A1, 8'h01);
        tick();
        chk("bp_a_data", out_data, 16'h00A1);
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_stall", stall_cnt, 0);
        push(16'h00B2, 8'h02);
        tick();
        chk("bp_full_occ", occupancy, 2);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_data", out_data, 16'h00A1);
        chk("bp_full_stall", stall_cnt, 1);
        push(16'h00C3, 8'h03);
        tick();
        chk("bp_c_held_occ", occupancy, 2);
        chk("bp_c_held_data", out_data, 16'h00A1);
        tick();
        chk("bp_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data", out_data, 16'h00B2);
        chk("bp_b_ctrl", out_ctrl, 8'h02);
        chk("bp_b_in_ready", in_ready, 1);
        chk("bp_b_occ", occupancy, 1);
        tick();
        chk("bp_c_data", out_data, 16'h00C3);
        chk("bp_c_ctrl", out_ctrl, 8'h03);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_final", stall_cnt, 3);

        // 4: flush from FULL, then from ONE with an accepted input
        out_ready = 1'b0;
        push(16'h00E5, 8'h05);
        tick();
        push(16'h00F6, 8'h06);
        tick();
        chk("fl_pre_occ", occupancy, 2);
        flush = 1'b1;
        push(16'h00DD, 8'hDD);
        tick();
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_stall_kept", stall_cnt, 5);
        flush = 1'b0;
        push(16'h0061, 8'h61);
        tick();
        chk("fl1_occ", occupancy, 1);
        flush = 1'b1;
        push(16'h00DD, 8'hDD);
        tick();
        chk("fl1_occ0", occupancy, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl1_no_d", out_valid, 0);
        chk("fl1_stall", stall_cnt, 6);
        out_ready = 1'b1;
        push(16'h0048, 8'h48);
        tick();
        chk("fl_after_data", out_data, 16'h0048);
        chk("fl_after_occ", occupancy, 1);
        in_valid = 1'b0;
        tick();

        // 5: stall counter saturation (CNT_W=4)
        out_ready = 1'b0;
        push(16'h0053, 8'h53);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", stall_cnt, 15);
        chk("sat_valid", out_valid, 1);
        chk("sat_data", out_data, 16'h0053);

        // 6: reset mid-operation
        push(16'h0054, 8'h54);
        tick();
        chk("mr_pre_occ", occupancy, 2);
        reset = 1'b1;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_occ", occupancy, 0);
        chk("mr_ctrl", out_ctrl, 0);
        chk("mr_data", out_data, 0);
        chk("mr_stall", stall_cnt, 0);
        reset = 1'b0; out_ready = 1'b1;
        push(16'h0077, 8'h07);
        tick();
        chk("mr_next_data", out_data, 16'h0077);
        chk("mr_next_ctrl", out_ctrl, 8'h07);
        chk("mr_next_occ", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("mr_alone", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
